store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the ALU result and the data memory write port. SW instructions are queued and retire to data memory as its write port accepts them, so a busy memory bank does not stall the pipeline until the queue fills. LW instructions are served in the same cycle, from the youngest matching queued store or else from the memory read port. The result feeds the LW leg of the write-data mux into the register file.

## Interface
- DEPTH, 4: number of store entries; power of two, at least 2.
- ADR_W, 10: word-address width; address = Result & (2^ADR_W − 1).

- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- Ins  in  32  current instruction; Ins[31:26] is the opcode; SW and LW come from common_param.vh.
- Result  in  32  ALU result, i.e. the effective address.
- Rdata2  in  32  store data.
- Stall  out  1  upstream must hold Ins/Result/Rdata2 while this is high.
- MemWE  out  1  write request to data memory.
- MemAdr  out  ADR_W  write address (head entry).
- MemWdata  out  32  write data (head entry).
- MemReady  in  1  memory accepts the write this cycle when MemWE && MemReady.
- LdAdr  out  ADR_W  async read address to memory = Result masked.
- LdData  in  32  async read data from memory.
- LoadData  out  32  load result.
- Empty  out  1  no entries pending.

## Operation
- State:
  - circular array of DEPTH {adr, data} entries;
  - head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, 0..DEPTH.
- Enqueue: opcode == SW && count < DEPTH. Writes {Result masked, Rdata2} at tail, then tail+1.
- Stall = (opcode == SW) && (count == DEPTH). Purely combinational from count and opcode, with no path from MemReady.
  - A SW arriving when full is not enqueued, even if the head drains that same cycle; it enqueues on the following cycle.
- Drain:
  - MemWE = (count != 0); MemAdr/MemWdata are the head entry.
  - On MemWE && MemReady at the edge, head advances by 1.
- Count update: count += enqueue − dequeue. Simultaneous enqueue and dequeue leaves count unchanged and advances both pointers.
- Load forwarding, when opcode == LW:
  - Compare the masked address against every valid entry (from head, for count entries).
  - LoadData = data of the youngest match (closest to tail); if there is no match, LoadData = LdData.
  - An entry being drained in this cycle is still valid and still forwards.
- LoadData is don't-care for non-LW opcodes. It is driven as LdData so it is never X.
- Other opcodes: no enqueue; drain continues.
- Empty = (count == 0).

## Timing
- On reset (asynchronous assert), all of these take effect immediately:
  - count = 0, head = 0, tail = 0;
  - MemWE = 0, Empty = 1, Stall = 0.
  - Entry contents are cleared to 0.
  - Pending stores are discarded.
- Reset deassertion is sampled at the next CLK edge; normal operation begins from the following edge.
- SW latency:
  - A SW present before edge k is enqueued at edge k.
  - MemWE is asserted in cycle k+1 at the earliest.
  - Memory is written at the first edge where MemReady = 1.
- With MemReady held at 1, the buffer never exceeds 1 entry for back-to-back SWs.
- LW has zero-cycle latency: LoadData is a combinational function of the current Ins/Result, the entries and LdData.
- Store-then-load to the same address:
  - The LW in the cycle after the SW sees the forwarded value.
  - After drain, the memory read returns the same value.
- Outputs MemWE/MemAdr/MemWdata depend only on registered state and carry no combinational input path.

## Test plan
1. **Reset drain:** RST=0 with 2 entries pending, then release -> Empty=1, MemWE=0; a LW to 0x010 returns LdData; no write of the discarded stores occurs.
2. **Single store:** SW adr 0x40 (word 0x040), data 0xDEADBEEF, MemReady=1 -> next cycle MemWE=1, MemAdr=0x040, MemWdata=0xDEADBEEF; after the edge, Empty=1.
3. **Youngest-match forwarding:** MemReady=0; SW word 5 = 0x11, SW word 5 = 0x22, then LW word 5 -> LoadData=0x22 while LdData=0x99; a LW to word 6 -> LoadData=0x99.
4. **Full stall:** MemReady=0; 4 SWs, then a 5th SW -> Stall=1, count stays 4. Raise MemReady for one cycle -> head drains while Stall remains 1 that cycle; the 5th SW enqueues on the next edge, Stall=0.
5. **Wrap-around:** with MemReady toggling, issue 10 SWs to words 0..9 with data = word×3 -> memory receives exactly the writes (0,0) … (9,27) in order; pointers wrap; Empty=1 at the end.
6. **Address masking:** SW Result=0x0000_0405 (masked 0x005), data 0xAB, then LW Result=0x0000_0005 -> LoadData=0xAB; MemAdr=0x005.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues SW writes toward data memory and
// forwards the youngest matching queued store to same-cycle LW reads.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADR_W = 10,
  parameter logic [5:0]  OP_SW = 6'b101011,
  parameter logic [5:0]  OP_LW = 6'b100011
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      Ins,
  input  logic [31:0]      Result,
  input  logic [31:0]      Rdata2,
  output logic             Stall,
  output logic             MemWE,
  output logic [ADR_W-1:0] MemAdr,
  output logic [31:0]      MemWdata,
  input  logic             MemReady,
  output logic [ADR_W-1:0] LdAdr,
  input  logic [31:0]      LdData,
  output logic [31:0]      LoadData,
  output logic             Empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADR_W-1:0] adr_q  [DEPTH];
  logic [ADR_W-1:0] adr_d  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [5:0]       opcode;
  logic [ADR_W-1:0] adr_m;
  logic             enq;
  logic             deq;
  logic             unused_ok;

  assign opcode    = Ins[31:26];
  assign adr_m     = Result[ADR_W-1:0];
  assign unused_ok = ^{Ins[25:0], Result[31:ADR_W]};

  // Drain side sees only registered state; Stall has no MemReady path.
  assign LdAdr    = adr_m;
  assign Stall    = (opcode == OP_SW) && (count_q == FULL);
  assign MemWE    = (count_q != '0);
  assign Empty    = (count_q == '0);
  assign MemAdr   = adr_q[head_q];
  assign MemWdata = data_q[head_q];

  // Queue next-state: enqueue at tail, retire head on accepted write.
  always_comb begin
    enq     = (opcode == OP_SW) && (count_q != FULL);
    deq     = (count_q != '0) && MemReady;
    adr_d   = adr_q;
    data_d  = data_q;
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    if (enq) begin
      adr_d[tail_q]  = adr_m;
      data_d[tail_q] = Rdata2;
    end
  end

  // Walk oldest to youngest so the last hit is the youngest match.
  always_comb begin : load_fwd
    logic [PTR_W-1:0] idx;
    LoadData = LdData;
    idx      = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((opcode == OP_LW) && (CNT_W'(i) < count_q) && (adr_q[idx] == adr_m)) begin
        LoadData = data_q[idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      adr_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int ADR_W = 10;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_R  = 6'b000000;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [31:0]      data;
  } ent_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [31:0]      Ins, Result, Rdata2, LdData, LoadData, MemWdata;
  logic             Stall, MemWE, MemReady, Empty;
  logic [ADR_W-1:0] MemAdr, LdAdr;

  ent_t        mdl_q[$];
  ent_t        wr_log[$];
  logic [31:0] mem_mdl [1024];
  int          errors = 0;
  int          checks = 0;

  store_buffer #(.DEPTH(DEPTH), .ADR_W(ADR_W), .OP_SW(OP_SW), .OP_LW(OP_LW)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Stall(Stall), .MemWE(MemWE), .MemAdr(MemAdr), .MemWdata(MemWdata),
    .MemReady(MemReady), .LdAdr(LdAdr), .LdData(LdData), .LoadData(LoadData),
    .Empty(Empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] res, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] ld);
    Ins      = {op, 26'($urandom)};
    Result   = res;
    Rdata2   = wd;
    MemReady = rdy;
    LdData   = ld;
    #1;
  endtask

  // Expected outputs straight from the queue contents.
  task automatic model_check();
    int               n;
    logic [ADR_W-1:0] a;
    logic [31:0]      exp_ld;
    n = mdl_q.size();
    a = Result[ADR_W-1:0];
    check("stall", 32'(Stall), 32'((Ins[31:26] == OP_SW) && (n == DEPTH)));
    check("memwe", 32'(MemWE), 32'(n != 0));
    check("empty", 32'(Empty), 32'(n == 0));
    check("ldadr", 32'(LdAdr), 32'(a));
    if (n != 0) begin
      check("memadr", 32'(MemAdr), 32'(mdl_q[0].adr));
      check("memwdata", MemWdata, mdl_q[0].data);
    end
    exp_ld = LdData;
    if (Ins[31:26] == OP_LW) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (mdl_q[i].adr == a) begin
          exp_ld = mdl_q[i].data;
          break;
        end
      end
    end
    check("loaddata", LoadData, exp_ld);
  endtask

  task automatic tick();
    bit   enq, deq;
    ent_t e;
    enq = RST && (Ins[31:26] == OP_SW) && (mdl_q.size() < DEPTH);
    deq = RST && (mdl_q.size() != 0) && MemReady;
    if (MemWE && MemReady) begin
      e.adr  = MemAdr;
      e.data = MemWdata;
      wr_log.push_back(e);
    end
    @(posedge CLK);
    if (deq) begin
      mem_mdl[mdl_q[0].adr] = mdl_q[0].data;
      void'(mdl_q.pop_front());
    end
    if (enq) begin
      e.adr  = Result[ADR_W-1:0];
      e.data = Rdata2;
      mdl_q.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic step(input logic [5:0] op, input logic [31:0] res, input logic [31:0] wd,
                      input logic rdy, input logic [31:0] ld);
    drive(op, res, wd, rdy, ld);
    model_check();
    tick();
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (mdl_q.size() != 0 && b < 20) begin
      step(OP_R, $urandom, 32'h0, 1'b1, $urandom);
      b++;
    end
    check("drain_empty", 32'(Empty), 32'h1);
  endtask

  initial begin
    bit          acc;
    int          cyc;
    logic [5:0]  op;
    logic [31:0] res;
    for (int i = 0; i < 1024; i++) mem_mdl[i] = 32'h0;
    Ins = 32'h0; Result = 32'h0; Rdata2 = 32'h0; MemReady = 1'b0; LdData = 32'h0;

    // Power-on reset
    @(negedge CLK);
    drive(OP_SW, 32'h10, 32'h1, 1'b1, 32'h0);
    check("por_memwe", 32'(MemWE), 32'h0);
    check("por_empty", 32'(Empty), 32'h1);
    check("por_stall", 32'(Stall), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    step(OP_R, 32'h0, 32'h0, 1'b0, 32'h0);

    // 1: reset with two stores pending discards them
    step(OP_SW, 32'h100, 32'hA1, 1'b0, 32'h0);
    step(OP_SW, 32'h104, 32'hA2, 1'b0, 32'h0);
    drive(OP_SW, 32'h108, 32'hA3, 1'b1, 32'h0);
    RST = 1'b0;
    #1;
    check("t1_memwe", 32'(MemWE), 32'h0);
    check("t1_empty", 32'(Empty), 32'h1);
    check("t1_stall", 32'(Stall), 32'h0);
    mdl_q.delete();
    wr_log.delete();
    tick();
    tick();
    RST = 1'b1;
    step(OP_R, 32'h0, 32'h0, 1'b1, 32'h0);
    drive(OP_LW, 32'h10, 32'h0, 1'b1, 32'h5A5A_5A5A);
    check("t1_lw", LoadData, 32'h5A5A_5A5A);
    model_check();
    tick();
    check("t1_nowrite", 32'(wr_log.size()), 32'h0);

    // 2: single store drains next cycle
    step(OP_SW, 32'h40, 32'hDEAD_BEEF, 1'b1, 32'h0);
    drive(OP_R, 32'h0, 32'h0, 1'b1, 32'h0);
    check("t2_memwe", 32'(MemWE), 32'h1);
    check("t2_memadr", 32'(MemAdr), 32'h040);
    check("t2_memwdata", MemWdata, 32'hDEAD_BEEF);
    model_check();
    tick();
    drive(OP_R, 32'h0, 32'h0, 1'b0, 32'h0);
    check("t2_empty", 32'(Empty), 32'h1);
    model_check();
    tick();

    // 3: youngest match wins, miss falls through to memory
    step(OP_SW, 32'h5, 32'h11, 1'b0, 32'h0);
    step(OP_SW, 32'h5, 32'h22, 1'b0, 32'h0);
    drive(OP_LW, 32'h5, 32'h0, 1'b0, 32'h99);
    check("t3_fwd", LoadData, 32'h22);
    model_check();
    tick();
    drive(OP_LW, 32'h6, 32'h0, 1'b0, 32'h99);
    check("t3_miss", LoadData, 32'h99);
    model_check();
    tick();
    drain();
    drive(OP_LW, 32'h5, 32'h0, 1'b0, mem_mdl[5]);
    check("t3_after_drain", LoadData, 32'h22);
    model_check();
    tick();

    // 4: full stall holds even while the head drains
    for (int i = 0; i < 4; i++) step(OP_SW, 32'(32'h20 + i), 32'(32'h100 + i), 1'b0, 32'h0);
    drive(OP_SW, 32'h24, 32'h104, 1'b0, 32'h0);
    check("t4_stall_full", 32'(Stall), 32'h1);
    model_check();
    tick();
    drive(OP_SW, 32'h24, 32'h104, 1'b1, 32'h0);
    check("t4_stall_drain", 32'(Stall), 32'h1);
    model_check();
    tick();
    drive(OP_SW, 32'h24, 32'h104, 1'b0, 32'h0);
    check("t4_stall_clear", 32'(Stall), 32'h0);
    check("t4_head", 32'(MemAdr), 32'h021);
    model_check();
    tick();
    drive(OP_SW, 32'h25, 32'h105, 1'b0, 32'h0);
    check("t4_refull", 32'(Stall), 32'h1);
    model_check();
    tick();
    drain();

    // 5: wrap-around with toggling MemReady
    wr_log.delete();
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      while (!acc && cyc < 200) begin
        drive(OP_SW, 32'(i), 32'(3 * i), 1'(cyc & 1), 32'h0);
        model_check();
        acc = (mdl_q.size() < DEPTH);
        tick();
        cyc++;
      end
    end
    drain();
    check("t5_nwr", 32'(wr_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
      check("t5_wr_adr", 32'(wr_log[i].adr), 32'(i));
      check("t5_wr_data", wr_log[i].data, 32'(3 * i));
    end

    // 6: address masking
    step(OP_SW, 32'h0000_0405, 32'hAB, 1'b0, 32'h0);
    drive(OP_LW, 32'h0000_0005, 32'h0, 1'b0, 32'h77);
    check("t6_fwd", LoadData, 32'hAB);
    check("t6_memadr", 32'(MemAdr), 32'h005);
    model_check();
    tick();
    drain();

    // Random traffic over a small address pool to exercise forwarding
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_SW;
        1:       op = OP_LW;
        default: op = OP_R;
      endcase
      res = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 7));
      step(op, res, $urandom, 1'($urandom_range(0, 3) == 0),
           (op == OP_LW && $urandom_range(0, 1) == 1) ? mem_mdl[res[ADR_W-1:0]] : $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

endmodule
